// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings and defaults for the memory port arbiter.
package mem_arb_pkg;
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_ISSUE = 2'd1;
   localparam state_t ST_WAIT  = 2'd2;
   localparam state_t ST_RESP  = 2'd3;
   localparam logic OWN_IF  = 1'b0;
   localparam logic OWN_MEM = 1'b1;
   localparam int DEF_TIMEOUT_CYCLES = 16;
endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: counts busy cycles and flags expiry on the LIMIT-th one.
module mem_arb_watchdog #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic expired
);
   localparam int CW = $clog2(LIMIT + 1);
   logic [CW-1:0] cnt;
   always_ff @(posedge clk)
      if (rst || clear) cnt <= '0;
      else if (en) cnt <= cnt + 1'b1;
   assign expired = en & (cnt == CW'(LIMIT - 1));
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IF fetches and MEM loads/stores.
// Optional watchdog timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
`ifdef MEM_ARB_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_stall,
   input  logic                mem_req,
   input  logic                mem_we,
   input  logic [DATA_W/8-1:0] mem_be,
   input  logic [ADDR_W-1:0]   mem_addr,
   input  logic [DATA_W-1:0]   mem_wdata,
   output logic                mem_done,
   output logic [DATA_W-1:0]   mem_rdata,
   output logic                mem_stall,
   output logic                mport_valid,
   input  logic                mport_ready,
   output logic                mport_we,
   output logic [DATA_W/8-1:0] mport_be,
   output logic [ADDR_W-1:0]   mport_addr,
   output logic [DATA_W-1:0]   mport_wdata,
   input  logic                mport_rvalid,
   input  logic [DATA_W-1:0]   mport_rdata,
   output logic                err
);
   state_t state;
   logic owner, last_owner, busy, got, timed_out, fin, pick_mem, expired;
   logic [DATA_W-1:0] rd;
   assign busy      = (state == ST_ISSUE) | (state == ST_WAIT);
   assign got       = (state == ST_WAIT) & mport_rvalid;
   assign timed_out = busy & expired & ~got;
   assign fin       = got | timed_out;
   assign rd        = timed_out ? '0 : mport_rdata;
   // MEM has priority unless it also finished last and IF is waiting
   assign pick_mem  = mem_req & ~(if_req & (last_owner == OWN_MEM));
   assign if_stall  = if_req & ~if_gnt;
   assign mem_stall = mem_req & ~mem_done;
   always_ff @(posedge clk)
      if (rst) begin
         state       <= ST_IDLE;
         owner       <= OWN_IF;
         last_owner  <= OWN_IF;
         if_gnt      <= 1'b0;
         mem_done    <= 1'b0;
         if_rdata    <= '0;
         mem_rdata   <= '0;
         mport_valid <= 1'b0;
         mport_we    <= 1'b0;
         mport_be    <= '0;
         mport_addr  <= '0;
         mport_wdata <= '0;
      end else begin
         if_gnt   <= fin & (owner == OWN_IF);
         mem_done <= fin & (owner == OWN_MEM);
         if (fin && owner == OWN_IF) if_rdata <= rd;
         if (fin && owner == OWN_MEM && !mport_we) mem_rdata <= rd;
         case (state)
            ST_IDLE:
               if (if_req || mem_req) begin
                  state       <= ST_ISSUE;
                  owner       <= pick_mem ? OWN_MEM : OWN_IF;
                  mport_valid <= 1'b1;
                  mport_we    <= pick_mem & mem_we;
                  mport_be    <= (pick_mem && mem_we) ? mem_be : '1;
                  mport_addr  <= pick_mem ? mem_addr : if_addr;
                  mport_wdata <= pick_mem ? mem_wdata : '0;
               end
            ST_ISSUE:
               if (timed_out || mport_ready) begin
                  state       <= timed_out ? ST_RESP : ST_WAIT;
                  mport_valid <= 1'b0;
               end
            ST_WAIT:
               if (fin) state <= ST_RESP;
            default: begin
               state      <= ST_IDLE;
               last_owner <= owner;
            end
         endcase
      end
`ifdef MEM_ARB_TIMEOUT_EN
   mem_arb_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wd (
      .clk     (clk),
      .rst     (rst),
      .clear   (~busy),
      .en      (busy),
      .expired (expired)
   );
   always_ff @(posedge clk)
      if (rst) err <= 1'b0;
      else if (timed_out) err <= 1'b1;
`else
   assign expired = 1'b0;
   assign err     = 1'b0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for the memory port arbiter.
module tb_mem_port_arbiter;
   typedef struct {logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata;} req_t;
   logic clk = 1'b0, rst = 1'b1;
   logic if_req = 0, if_gnt, if_stall, mem_req = 0, mem_we = 0, mem_done, mem_stall;
   logic [31:0] if_addr = 0, if_rdata, mem_addr = 0, mem_wdata = 0, mem_rdata;
   logic [3:0] mem_be = 0, mport_be;
   logic mport_valid, mport_ready = 1, mport_we, mport_rvalid = 0, err;
   logic [31:0] mport_addr, mport_wdata, mport_rdata = 0;
   req_t exp_req[$], mem_q[$];
   logic [31:0] if_q[$], exp_if[$], exp_mem[$];
   logic [31:0] memv [logic [31:0]];
   int checks = 0, failures = 0, cyc = 0, t_done = 0, t_gnt = 0;
   logic rv_en = 1'b1;
   logic [31:0] last_ld = 0;
   always #5 clk = ~clk;
   mem_port_arbiter dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_stall(if_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
      .mport_valid(mport_valid), .mport_ready(mport_ready), .mport_we(mport_we), .mport_be(mport_be),
      .mport_addr(mport_addr), .mport_wdata(mport_wdata), .mport_rvalid(mport_rvalid),
      .mport_rdata(mport_rdata), .err(err)
   );
   function automatic req_t mk(logic we, logic [3:0] be, logic [31:0] addr, logic [31:0] wdata);
      req_t r;
      r.we = we; r.be = be; r.addr = addr; r.wdata = wdata;
      return r;
   endfunction
   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask
   task automatic drive_mem(req_t m);
      mem_we = m.we; mem_be = m.be; mem_addr = m.addr; mem_wdata = m.wdata; mem_req = 1'b1;
   endtask
   task automatic issue_mem(logic we, logic [3:0] be, logic [31:0] addr, logic [31:0] wdata, logic [31:0] exp_rd);
      exp_mem.push_back(we ? last_ld : exp_rd);
      if (!we) last_ld = exp_rd;
      if (!mem_req) drive_mem(mk(we, be, addr, wdata));
      else mem_q.push_back(mk(we, be, addr, wdata));
   endtask
   task automatic issue_if(logic [31:0] addr, logic [31:0] exp_rd);
      exp_if.push_back(exp_rd);
      if (!if_req) begin if_addr = addr; if_req = 1'b1; end
      else if_q.push_back(addr);
   endtask
   // One clock: score any accepted request, model the memory, advance requesters, check outputs
   task automatic tick();
      logic acc, gi, md;
      logic [31:0] w;
      req_t r, e;
      acc = mport_valid & mport_ready;
      gi = if_gnt;
      md = mem_done;
      r = mk(mport_we, mport_be, mport_addr, mport_wdata);
      if (acc) begin
         if (exp_req.size() == 0) chk("req_spurious", acc, 0);
         else begin
            e = exp_req.pop_front();
            chk("req_we", r.we, e.we);
            chk("req_be", r.be, e.be);
            chk("req_addr", r.addr, e.addr);
            if (e.we) chk("req_wdata", r.wdata, e.wdata);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      mport_rvalid = 1'b0;
      if (acc && r.we) begin
         w = memv.exists(r.addr) ? memv[r.addr] : 32'h0;
         for (int b = 0; b < 4; b++) if (r.be[b]) w[8*b +: 8] = r.wdata[8*b +: 8];
         memv[r.addr] = w;
      end
      if (acc && rv_en) begin
         mport_rvalid = 1'b1;
         mport_rdata = r.we ? 32'h0 : (memv.exists(r.addr) ? memv[r.addr] : 32'h0);
      end
      if (gi) begin
         if (if_q.size() != 0) if_addr = if_q.pop_front();
         else if_req = 1'b0;
      end
      if (md) begin
         if (mem_q.size() != 0) drive_mem(mem_q.pop_front());
         else mem_req = 1'b0;
      end
      #1;
      if (if_gnt) begin
         t_gnt = cyc;
         if (exp_if.size() != 0) chk("if_rdata", if_rdata, exp_if.pop_front());
         else chk("if_gnt_spurious", if_gnt, 0);
      end
      if (mem_done) begin
         t_done = cyc;
         if (exp_mem.size() != 0) chk("mem_rdata", mem_rdata, exp_mem.pop_front());
         else chk("mem_done_spurious", mem_done, 0);
      end
      chk("if_stall", if_stall, if_req & ~if_gnt);
      chk("mem_stall", mem_stall, mem_req & ~mem_done);
   endtask
   task automatic drain(int max);
      for (int i = 0; i < max && (exp_if.size() + exp_mem.size() + exp_req.size()) != 0; i++) tick();
      chk("drain_pending", exp_if.size() + exp_mem.size() + exp_req.size(), 0);
      tick();
      tick();
   endtask
   initial begin
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_valid", mport_valid, 0);
      chk("rst_gnt", if_gnt, 0);
      chk("rst_done", mem_done, 0);
      chk("rst_err", err, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_addr", mport_addr, 0);
      // Minimum-latency fetch
      memv[32'h0] = 32'h00500093;
      exp_req.push_back(mk(1'b0, 4'hF, 32'h0, 32'h0));
      issue_if(32'h0, 32'h00500093);
      #1;
      chk("t1_stall_c0", if_stall, 1);
      chk("t1_valid_c0", mport_valid, 0);
      tick();
      chk("t1_valid_c1", mport_valid, 1);
      chk("t1_addr_c1", mport_addr, 32'h0);
      chk("t1_gnt_c1", if_gnt, 0);
      tick();
      chk("t1_gnt_c2", if_gnt, 0);
      tick();
      chk("t1_gnt_c3", if_gnt, 1);
      chk("t1_rdata_c3", if_rdata, 32'h00500093);
      tick();
      tick();
      // Simultaneous IF read and MEM store: MEM goes first
      memv[32'h4] = 32'h00a00113;
      exp_req.push_back(mk(1'b1, 4'hF, 32'd200, 32'd1));
      exp_req.push_back(mk(1'b0, 4'hF, 32'h4, 32'h0));
      issue_if(32'h4, 32'h00a00113);
      issue_mem(1'b1, 4'hF, 32'd200, 32'd1, 32'h0);
      drain(30);
      chk("t2_done_before_gnt", t_done < t_gnt, 1);
      // Back-to-back loads with IF pending: starvation guard interleaves IF
      memv[32'd204] = 32'h11112222;
      memv[32'd208] = 32'h33334444;
      memv[32'h8] = 32'h00000013;
      exp_req.push_back(mk(1'b0, 4'hF, 32'd204, 32'h0));
      exp_req.push_back(mk(1'b0, 4'hF, 32'h8, 32'h0));
      exp_req.push_back(mk(1'b0, 4'hF, 32'd208, 32'h0));
      exp_req.push_back(mk(1'b0, 4'hF, 32'd200, 32'h0));
      issue_mem(1'b0, 4'h0, 32'd204, 32'hFFFFFFFF, 32'h11112222);
      issue_mem(1'b0, 4'h0, 32'd208, 32'hFFFFFFFF, 32'h33334444);
      issue_mem(1'b0, 4'h0, 32'd200, 32'hFFFFFFFF, 32'd1);
      issue_if(32'h8, 32'h00000013);
      drain(60);
      // Memory back-pressure in ISSUE
      mport_ready = 1'b0;
      exp_req.push_back(mk(1'b1, 4'h3, 32'd300, 32'hDEADBEEF));
      issue_mem(1'b1, 4'h3, 32'd300, 32'hDEADBEEF, 32'h0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t4_valid", mport_valid, 1);
         chk("t4_addr", mport_addr, 32'd300);
         chk("t4_wdata", mport_wdata, 32'hDEADBEEF);
         chk("t4_be", mport_be, 4'h3);
         chk("t4_done", mem_done, 0);
      end
      mport_ready = 1'b1;
      drain(20);
      // Reset while waiting for the response; late rvalid must be ignored
      rv_en = 1'b0;
      exp_req.push_back(mk(1'b0, 4'hF, 32'h10, 32'h0));
      if_addr = 32'h10;
      if_req = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      if_req = 1'b0;
      last_ld = 32'h0;
      #1;
      chk("t5_valid", mport_valid, 0);
      chk("t5_if_rdata", if_rdata, 0);
      chk("t5_mem_rdata", mem_rdata, 0);
      chk("t5_addr", mport_addr, 0);
      chk("t5_we", mport_we, 0);
      chk("t5_be", mport_be, 0);
      tick();
      mport_rvalid = 1'b1;
      mport_rdata = 32'h0BAD0BAD;
      repeat (4) tick();
      chk("t5_gnt", if_gnt, 0);
      chk("t5_valid_late", mport_valid, 0);
      chk("t5_if_rdata_late", if_rdata, 0);
      // Response that never arrives
      memv[32'd400] = 32'h55556666;
      exp_req.push_back(mk(1'b0, 4'hF, 32'd400, 32'h0));
`ifdef MEM_ARB_TIMEOUT_EN
      issue_mem(1'b0, 4'h0, 32'd400, 32'h0, 32'h0);
      drain(30);
      chk("t6_err", err, 1);
      repeat (3) tick();
      chk("t6_err_held", err, 1);
`else
      issue_mem(1'b0, 4'h0, 32'd400, 32'h0, 32'h55556666);
      repeat (40) tick();
      chk("t6_err", err, 0);
      chk("t6_valid", mport_valid, 0);
      chk("t6_stall", mem_stall, 1);
      mport_rvalid = 1'b1;
      mport_rdata = 32'h55556666;
      drain(10);
      chk("t6_err_after", err, 0);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
